// File: rtl/traffic_controller_timed.sv
// Purpose : farm/highway four-phase traffic light controller, single clock with tick prescaler.
// Latency : vehicle_in -> req after 3 clk edges; state changes on the clk edge ending a tick cycle.
// Backpr. : none; free-running, with no handshake on any input or output.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high
//   vehicle_in    raw farm-road sensor (asynchronous to clk)
//   highway_light one-hot {R,Y,G} for the highway
//   farm_light    one-hot {R,Y,G} for the farm road
//   state_code    0=HG 1=HY 2=FG 3=FY
//   state7seg     active-low segments {g..a} showing state_code
//   tick          one-clk phase-tick strobe
//   enable        seven-segment digit enable (active-low, tied on)
module traffic_controller_timed #(
    parameter int TICK_DIV = 100000000,
    parameter int HG_MIN   = 3,
    parameter int Y_TICKS  = 1,
    parameter int FG_MIN   = 1,
    parameter int FG_MAX   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vehicle_in,
    output logic [2:0] highway_light,
    output logic [2:0] farm_light,
    output logic [1:0] state_code,
    output logic [6:0] state7seg,
    output logic       tick,
    output logic       enable
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_AB = (HG_MIN > Y_TICKS) ? HG_MIN : Y_TICKS;
    localparam int MAX_CD = (FG_MIN > FG_MAX) ? FG_MIN : FG_MAX;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP + 1) : 1;
    // elapsed needs one extra bit so phase_cnt at saturation + 1 cannot wrap
    localparam int EW     = CW + 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] HG_MIN_C  = EW'(HG_MIN);
    localparam logic [EW-1:0] Y_TICKS_C = EW'(Y_TICKS);
    localparam logic [EW-1:0] FG_MIN_C  = EW'(FG_MIN);
    localparam logic [EW-1:0] FG_MAX_C  = EW'(FG_MAX);

    typedef enum logic [1:0] {
        S_HG = 2'd0,
        S_HY = 2'd1,
        S_FG = 2'd2,
        S_FY = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] pre_cnt;
    logic [CW-1:0] phase_cnt;
    logic [EW-1:0] elapsed;
    logic          phase_exit;
    logic          sync1;
    logic          veh_s;
    logic          veh_d;
    logic          veh_rise;
    logic          req;
    logic          demand;
    logic          enter_fg;

    // ------------------------------------------------------------------
    // Tick prescaler: counts 0..TICK_DIV-1, strobe on the last count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // Gated by reset so a TICK_DIV=1 build still shows tick=0 while held in reset.
    assign tick = (pre_cnt == PRE_LAST) && !reset;

    // ------------------------------------------------------------------
    // Vehicle sensor: two-flop synchroniser plus one flop for edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            veh_s <= 1'b0;
            veh_d <= 1'b0;
        end else begin
            sync1 <= vehicle_in;
            veh_s <= sync1;
            veh_d <= veh_s;
        end
    end

    assign veh_rise = veh_s && !veh_d;

    // ------------------------------------------------------------------
    // Demand latch. A rise seen while already in FG is being served by the
    // green in progress, so it is not latched. Entering FG clears the latch
    // and takes priority over a rise in the same cycle.
    // ------------------------------------------------------------------
    assign enter_fg = (state_next == S_FG) && (state != S_FG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req <= 1'b0;
        end else if (enter_fg) begin
            req <= 1'b0;
        end else if (veh_rise && (state != S_FG)) begin
            req <= 1'b1;
        end
    end

    assign demand = req || veh_s;

    // ------------------------------------------------------------------
    // Phase FSM
    // ------------------------------------------------------------------
    assign elapsed = {1'b0, phase_cnt} + EW'(1);

    always_comb begin
        state_next = state;
        phase_exit = 1'b0;
        if (tick) begin
            unique case (state)
                S_HG: phase_exit = (elapsed >= HG_MIN_C) && demand;
                S_HY: phase_exit = (elapsed == Y_TICKS_C);
                S_FG: phase_exit = ((elapsed >= FG_MIN_C) && !veh_s) ||
                                   (elapsed == FG_MAX_C);
                S_FY: phase_exit = (elapsed == Y_TICKS_C);
                default: phase_exit = 1'b0;
            endcase
        end
        if (phase_exit) begin
            unique case (state)
                S_HG:    state_next = S_HY;
                S_HY:    state_next = S_FG;
                S_FG:    state_next = S_FY;
                S_FY:    state_next = S_HG;
                default: state_next = S_HG;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_HG;
        end else begin
            state <= state_next;
        end
    end

    // Counts ticks spent in the current phase; saturates so a long HG
    // with no demand cannot wrap back below HG_MIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (tick) begin
            if (phase_exit) begin
                phase_cnt <= '0;
            end else if (phase_cnt != '1) begin
                phase_cnt <= phase_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from the state register only
    // ------------------------------------------------------------------
    always_comb begin
        highway_light = 3'b001;
        farm_light    = 3'b100;
        state7seg     = 7'b1000000;
        unique case (state)
            S_HG: begin
                highway_light = 3'b001;
                farm_light    = 3'b100;
                state7seg     = 7'b1000000;
            end
            S_HY: begin
                highway_light = 3'b010;
                farm_light    = 3'b100;
                state7seg     = 7'b1111001;
            end
            S_FG: begin
                highway_light = 3'b100;
                farm_light    = 3'b001;
                state7seg     = 7'b0100100;
            end
            S_FY: begin
                highway_light = 3'b100;
                farm_light    = 3'b010;
                state7seg     = 7'b0110000;
            end
            default: begin
                highway_light = 3'b001;
                farm_light    = 3'b100;
                state7seg     = 7'b1000000;
            end
        endcase
    end

    assign state_code = state;
    assign enable     = 1'b0;

endmodule

// File: tb/tb_traffic_controller_timed.sv
// Purpose : self-checking bench for traffic_controller_timed with a transition scoreboard.
// Latency : expected transitions carry the clk-edge count at which they must appear.
// Backpr. : none; the monitor pops one expectation per observed state_code change.
module tb_traffic_controller_timed;

    logic       clk;
    logic       reset;
    logic       vehicle_in;
    logic [2:0] highway_light;
    logic [2:0] farm_light;
    logic [1:0] state_code;
    logic [6:0] state7seg;
    logic       tick;
    logic       enable;

    traffic_controller_timed #(
        .TICK_DIV(4),
        .HG_MIN  (3),
        .Y_TICKS (2),
        .FG_MIN  (2),
        .FG_MAX  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .vehicle_in   (vehicle_in),
        .highway_light(highway_light),
        .farm_light   (farm_light),
        .state_code   (state_code),
        .state7seg    (state7seg),
        .tick         (tick),
        .enable       (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // clk edges since reset release
    int cyc;
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [1:0] code;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [1:0] last_code = 2'd0;

    function automatic logic [2:0] hw_of(input logic [1:0] c);
        case (c)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] farm_of(input logic [1:0] c);
        case (c)
            2'd2:    return 3'b001;
            2'd3:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input logic [1:0] c);
        case (c)
            2'd0:    return 7'b1000000;
            2'd1:    return 7'b1111001;
            2'd2:    return 7'b0100100;
            default: return 7'b0110000;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic push(input logic [1:0] c, input int at);
        exp_t e;
        e.code = c;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: samples on the falling edge, pops one expectation per change.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_code = 2'd0;
        end else begin
            check("both_roads_not_green", int'(highway_light != 3'b100 && farm_light != 3'b100), 0);
            if (state_code != last_code) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_transition: got state %0d at cyc %0d, expected none",
                             state_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("trans_state", int'(state_code), int'(e.code));
                    check("trans_cycle", cyc, e.at);
                    check("trans_hw_light", int'(highway_light), int'(hw_of(e.code)));
                    check("trans_farm_light", int'(farm_light), int'(farm_of(e.code)));
                    check("trans_7seg", int'(state7seg), int'(seg_of(e.code)));
                end
                last_code = state_code;
            end
        end
    end

    initial begin
        vehicle_in = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst_hw_light", int'(highway_light), 3'b001);
        check("rst_farm_light", int'(farm_light), 3'b100);
        check("rst_state_code", int'(state_code), 0);
        check("rst_7seg", int'(state7seg), 7'b1000000);
        check("rst_tick", int'(tick), 0);
        check("rst_enable", int'(enable), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle: no vehicle for 200 clk, tick every 4th cycle, stay in HG.
        for (int k = 1; k <= 200; k++) begin
            wait_cyc(k);
            check("idle_tick", int'(tick), int'((k % 4) == 3));
            check("idle_state", int'(state_code), 0);
        end
        check("idle_drained", exp_q.size(), 0);
        do_reset();

        // Short pulse at clk 30: req sets at edge 33, first tick after is edge 36.
        push(2'd1, 36);
        push(2'd2, 44);
        push(2'd3, 52);
        push(2'd0, 60);
        wait_cyc(30); vehicle_in = 1'b1;
        wait_cyc(32); vehicle_in = 1'b0;
        wait_cyc(90);
        check("pulse_drained", exp_q.size(), 0);
        do_reset();

        // Vehicle held: HG_MIN boundary at edge 12, FG capped at 5 ticks, HG 3 ticks again.
        push(2'd1, 12);
        push(2'd2, 20);
        push(2'd3, 40);
        push(2'd0, 48);
        push(2'd1, 60);
        wait_cyc(2); vehicle_in = 1'b1;
        wait_cyc(64);
        check("held_drained", exp_q.size(), 0);
        vehicle_in = 1'b0;
        do_reset();

        // Rise during FY is latched and served after HG_MIN.
        push(2'd1, 36);
        push(2'd2, 44);
        push(2'd3, 52);
        push(2'd0, 60);
        push(2'd1, 72);
        push(2'd2, 80);
        push(2'd3, 88);
        push(2'd0, 96);
        wait_cyc(30); vehicle_in = 1'b1;
        wait_cyc(32); vehicle_in = 1'b0;
        wait_cyc(53); vehicle_in = 1'b1;
        wait_cyc(55); vehicle_in = 1'b0;
        wait_cyc(140);
        check("fy_req_drained", exp_q.size(), 0);
        do_reset();

        // Reset mid-FG, asserted between clk edges.
        push(2'd1, 36);
        push(2'd2, 44);
        wait_cyc(30); vehicle_in = 1'b1;
        wait_cyc(32); vehicle_in = 1'b0;
        wait_cyc(46);
        check("midfg_state_before", int'(state_code), 2);
        #2 reset = 1'b1;
        #1;
        check("midfg_hw_light", int'(highway_light), 3'b001);
        check("midfg_farm_light", int'(farm_light), 3'b100);
        check("midfg_7seg", int'(state7seg), 7'b1000000);
        check("midfg_state_code", int'(state_code), 0);
        check("midfg_drained", exp_q.size(), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("midfg_req_after_release", int'(dut.req), 0);
        wait_cyc(60);
        check("midfg_req_later", int'(dut.req), 0);
        check("midfg_state_later", int'(state_code), 0);
        check("midfg_final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
